// File: rtl/sipo_frame_pkg.sv
// Shared types for the serial frame controller. The PARITY state is used only
// when SIPO_FRAME_PARITY_EN is defined.
package sipo_frame_pkg;

  localparam int MIN_WIDTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/sipo_shift_en.sv
// WIDTH-bit serial-in/parallel-out shift register. It shifts in at the LSB
// only while shift_en is high, so the first bit received ends up at the MSB.
module sipo_shift_en #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) sr_d = {sr_q[WIDTH-2:0], din};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge, whatever the process order.
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

  assign q = sr_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: start-bit detect, WIDTH-bit capture, and a valid/ready
// output register with a sticky overrun flag. SIPO_FRAME_PARITY_EN adds one
// even-parity bit after the data bits and a par_err output.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             serial_in,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SIPO_FRAME_PARITY_EN
  output logic             par_err,
`endif
  output logic             busy,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] sr;
  logic             shift_en, load, drop;
`ifdef SIPO_FRAME_PARITY_EN
  logic             par_bit_q, par_bit_d;
  logic             par_err_q, par_err_d;
`endif

  sipo_shift_en #(.WIDTH(WIDTH)) u_sr (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .din      (serial_in),
    .q        (sr)
  );

  // NOTE: every signal assigned here gets its default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = 1'b0;
    load      = 1'b0;
    drop      = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
    par_bit_d = par_bit_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (serial_in) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en  = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
`ifdef SIPO_FRAME_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_PARITY: begin
`ifdef SIPO_FRAME_PARITY_EN
        par_bit_d = serial_in;
        state_d   = ST_DONE;
`else
        state_d   = ST_IDLE;
`endif
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        // A pending word that is not being accepted right now wins over the new frame.
        if (valid_q && !out_ready) drop = 1'b1;
        else                       load = 1'b1;
      end
    endcase
    // With en low, any partial frame is abandoned and the output side is left alone.
    if (!en) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_en  = 1'b0;
      load      = 1'b0;
      drop      = 1'b0;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
`ifdef SIPO_FRAME_PARITY_EN
    par_err_d = par_err_q;
`endif
    if (valid_q && out_ready) valid_d = 1'b0;
    if (load) begin
      data_d  = sr;
      valid_d = 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
      par_err_d = ^{sr, par_bit_q};
`endif
    end
    if (clr_ovr) ovr_d = 1'b0;
    if (drop)    ovr_d = 1'b1;
  end

  // NOTE: the reset is synchronous, so it only takes effect on a clock edge
  // and is written as the first branch inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`endif

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl (WIDTH=4). A table of frames is sent
// with out_ready high, then hand-written sequences cover the corner cases.
module tb_sipo_frame_ctrl;

  localparam int WIDTH = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, en, serial_in, clr_ovr, out_ready;
  logic [WIDTH-1:0] data_out;
  logic             out_valid, busy, overrun;
`ifdef SIPO_FRAME_PARITY_EN
  logic             par_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] sb_q[$];

  sipo_frame_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .serial_in (serial_in),
    .clr_ovr   (clr_ovr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SIPO_FRAME_PARITY_EN
    .par_err   (par_err),
`endif
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every accepted word must match the oldest expected word.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h with no word expected at %0t", data_out, $time);
      end else begin
        check("sb_word", 32'(data_out), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start bit, WIDTH data bits MSB first, optional parity bit, then the DONE cycle.
  task automatic send_frame(input logic [WIDTH-1:0] w, input logic rdy_done, input logic bad_par);
    serial_in = 1'b1;
    step();
    check("busy_start", 32'(busy), 32'd1);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      serial_in = w[i];
      step();
      check("busy_shift", 32'(busy), 32'd1);
    end
    if (PAR) begin
      serial_in = (^w) ^ bad_par;
      step();
      check("busy_par", 32'(busy), 32'd1);
    end
    serial_in = 1'b0;
    if (rdy_done) out_ready = 1'b1;
    step();
    check("busy_done", 32'(busy), 32'd0);
    if (rdy_done) out_ready = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] word;
    int               gap;
    logic [WIDTH-1:0] exp_data;
    logic             exp_valid;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{word: 4'b1001, gap: 2, exp_data: 4'h9, exp_valid: 1'b1};
    vecs[1] = '{word: 4'b0110, gap: 0, exp_data: 4'h6, exp_valid: 1'b1};
    vecs[2] = '{word: 4'b0000, gap: 1, exp_data: 4'h0, exp_valid: 1'b1};
    vecs[3] = '{word: 4'b1111, gap: 0, exp_data: 4'hF, exp_valid: 1'b1};
    vecs[4] = '{word: 4'b1010, gap: 3, exp_data: 4'hA, exp_valid: 1'b1};
    vecs[5] = '{word: 4'b0011, gap: 0, exp_data: 4'h3, exp_valid: 1'b1};

    rst = 1'b1; en = 1'b0; serial_in = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'd0);

    // Table: each frame loads and is accepted one cycle later; back-to-back frames with gap 0.
    out_ready = 1'b1;
    foreach (vecs[k]) begin
      for (int g = 0; g < vecs[k].gap; g++) step();
      sb_q.push_back(vecs[k].exp_data);
      send_frame(vecs[k].word, 1'b0, 1'b0);
      check("tbl_data", 32'(data_out), 32'(vecs[k].exp_data));
      check("tbl_valid", 32'(out_valid), 32'(vecs[k].exp_valid));
      check("tbl_ovr", 32'(overrun), 32'd0);
    end
    step();
    check("tbl_drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    step();

    // Basic frame plus handshake: word held 3 cycles, accepted on a one-cycle ready pulse.
    sb_q.push_back(4'b1001);
    send_frame(4'b1001, 1'b0, 1'b0);
    check("basic_data", 32'(data_out), 32'h9);
    check("basic_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_data", 32'(data_out), 32'h9);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("accept_valid", 32'(out_valid), 32'd0);

    // Overrun: second frame dropped while the first is pending; then cleared.
    sb_q.push_back(4'b1001);
    send_frame(4'b1001, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    check("ovr_data", 32'(data_out), 32'h9);
    check("ovr_valid", 32'(out_valid), 32'd1);
    check("ovr_set", 32'(overrun), 32'd1);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ovr_drain", 32'(out_valid), 32'd0);

    // Accept and load on the same DONE edge.
    sb_q.push_back(4'b1001);
    send_frame(4'b1001, 1'b0, 1'b0);
    sb_q.push_back(4'b0110);
    send_frame(4'b0110, 1'b1, 1'b0);
    check("same_data", 32'(data_out), 32'h6);
    check("same_valid", 32'(out_valid), 32'd1);
    check("same_ovr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("same_drain", 32'(out_valid), 32'd0);

    // Abort: en dropped after two data bits, then a clean frame.
    serial_in = 1'b1;
    step();
    serial_in = 1'b1;
    step();
    step();
    en = 1'b0;
    serial_in = 1'b0;
    step();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    sb_q.push_back(4'b1100);
    send_frame(4'b1100, 1'b0, 1'b0);
    check("abort_data", 32'(data_out), 32'hC);
    check("abort_new_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef SIPO_FRAME_PARITY_EN
    sb_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b0, 1'b0);
    check("par_ok_err", 32'(par_err), 32'd0);
    check("par_ok_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    sb_q.push_back(4'b1011);
    send_frame(4'b1011, 1'b0, 1'b1);
    check("par_bad_err", 32'(par_err), 32'd1);
    check("par_bad_data", 32'(data_out), 32'hB);
    check("par_bad_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif

    // Reset mid-frame with a pending word and overrun set.
    send_frame(4'b1010, 1'b0, 1'b0);
    send_frame(4'b0101, 1'b0, 1'b0);
    check("pre_rst_ovr", 32'(overrun), 32'd1);
    serial_in = 1'b1;
    step();
    step();
    rst = 1'b1;
    serial_in = 1'b0;
    step();
    check("mrst_data", 32'(data_out), 32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;
    step();

    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
